lcd_num_sequencer: RTL and testbench

//  Drives the DE2-115 HD44780 character LCD (8-bit bus, write-only) so that one signed
//   16-bit CPU value is shown as sign + 5 digits, e.g. "-00042".

---
 rtl/lcd_num_sequencer.sv | 177 +++++++++++++++++
 tb/tb_lcd_num_sequencer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/lcd_num_sequencer.sv
// HD44780 sequencer: power-up init, then shows a signed 16-bit value
// as sign + 5 decimal digits via req/ready.
module lcd_num_sequencer #(
  parameter int T_PWRUP = 2_000_000,
  parameter int T_EN    = 25,
  parameter int T_CMD   = 2_500,
  parameter int T_CLR   = 100_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [15:0] numero,
  output logic        ready,
  output logic        init_done,
  output logic [7:0]  lcd_data,
  output logic        lcd_rs,
  output logic        lcd_en,
  output logic        lcd_rw
);

  typedef enum logic [2:0] {
    S_PWRUP, S_INIT, S_IDLE, S_CONV, S_HOME, S_WRITE
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [15:0] num_q, num_d;
  logic [15:0] bin_q, bin_d;
  logic [19:0] bcd_q, bcd_d;
  logic        init_q, init_d;

  logic        xfer, last;
  logic [31:0] post;
  logic [15:0] mag;
  logic [19:0] adj;
  logic [3:0]  dig;
  logic [7:0]  byte_c;

  // 16-bit negate yields 0x8000 for -32768, which is the correct magnitude
  assign mag  = num_q[15] ? (~num_q + 16'd1) : num_q;
  assign xfer = (state_q == S_INIT) || (state_q == S_HOME) ||
                (state_q == S_WRITE);
  assign post = (state_q == S_INIT && idx_q == 3'd2) ?
                32'(T_CLR) : 32'(T_CMD);
  assign last = (cnt_q == 32'(T_EN) + post);

  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < 5; i++)
      if (bcd_q[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
  end

  always_comb begin
    dig = 4'h0;
    case (idx_q)
      3'd1:    dig = bcd_q[19:16];
      3'd2:    dig = bcd_q[15:12];
      3'd3:    dig = bcd_q[11:8];
      3'd4:    dig = bcd_q[7:4];
      default: dig = bcd_q[3:0];
    endcase
  end

  always_comb begin
    byte_c = 8'h00;
    unique case (state_q)
      S_INIT: begin
        case (idx_q)
          3'd0:    byte_c = 8'h38;
          3'd1:    byte_c = 8'h0C;
          3'd2:    byte_c = 8'h01;
          default: byte_c = 8'h06;
        endcase
      end
      S_HOME:  byte_c = 8'h80;
      S_WRITE: begin
        if (idx_q == 3'd0) byte_c = num_q[15] ? 8'h2D : 8'h2B;
        else               byte_c = 8'h30 + {4'h0, dig};
      end
      default: byte_c = 8'h00;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 32'd1;
    idx_d   = idx_q;
    num_d   = num_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    init_d  = init_q;
    unique case (state_q)
      S_PWRUP: begin
        if (cnt_q >= 32'(T_PWRUP) - 32'd1) begin
          state_d = S_INIT;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end
      S_INIT: begin
        if (last) begin
          cnt_d = '0;
          if (idx_q == 3'd3) begin
            state_d = S_IDLE;
            init_d  = 1'b1;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      S_IDLE: begin
        cnt_d = '0;
        if (req) begin
          num_d   = numero;
          state_d = S_CONV;
        end
      end
      S_CONV: begin
        if (cnt_q == '0) begin
          bin_d = mag;
          bcd_d = '0;
        end else begin
          {bcd_d, bin_d} = {adj, bin_q} << 1;
          if (cnt_q == 32'd16) begin
            state_d = S_HOME;
            cnt_d   = '0;
          end
        end
      end
      S_HOME: begin
        if (last) begin
          state_d = S_WRITE;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end
      S_WRITE: begin
        if (last) begin
          cnt_d = '0;
          if (idx_q == 3'd5) state_d = S_IDLE;
          else               idx_d   = idx_q + 3'd1;
        end
      end
      default: state_d = S_PWRUP;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_PWRUP;
      cnt_q   <= '0;
      idx_q   <= '0;
      num_q   <= '0;
      bin_q   <= '0;
      bcd_q   <= '0;
      init_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      num_q   <= num_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      init_q  <= init_d;
    end
  end

  assign lcd_data  = byte_c;
  assign lcd_rs    = (state_q == S_WRITE);
  assign lcd_en    = xfer && (cnt_q != '0) && (cnt_q <= 32'(T_EN));
  assign lcd_rw    = 1'b0;
  assign ready     = (state_q == S_IDLE);
  assign init_done = init_q;

endmodule

// File: tb/tb_lcd_num_sequencer.sv
// Bench for lcd_num_sequencer: init sequence, value rendering,
// handshake latency, busy-request rejection, reset mid-transfer.
module tb_lcd_num_sequencer;

  localparam int TPW  = 50;
  localparam int TEN  = 4;
  localparam int TCMD = 10;
  localparam int TCLR = 20;
  localparam int LAT  = 17 + 7 * (1 + TEN + TCMD);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic [15:0] numero = '0;
  logic        ready, init_done, lcd_rs, lcd_en, lcd_rw;
  logic [7:0]  lcd_data;

  int n_tests = 0;
  int n_fail  = 0;

  logic [8:0] cap_q[$];
  logic [8:0] exp_q[$];
  logic [8:0] init_exp[4] = '{9'h038, 9'h00C, 9'h001, 9'h006};

  lcd_num_sequencer #(
    .T_PWRUP(TPW), .T_EN(TEN), .T_CMD(TCMD), .T_CLR(TCLR)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .numero(numero),
    .ready(ready), .init_done(init_done),
    .lcd_data(lcd_data), .lcd_rs(lcd_rs),
    .lcd_en(lcd_en), .lcd_rw(lcd_rw)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse monitor: captures each byte and checks width/stability/gap
  logic       prev_en = 1'b0;
  logic [8:0] prev_b  = '0;
  logic [8:0] hold    = '0;
  int         hi_n    = 0;
  int         post_n  = 0;
  int         post_len = 0;
  logic       in_post = 1'b0;

  always @(negedge clk) begin
    logic [8:0] cur;
    cur = {lcd_rs, lcd_data};
    if (rst) begin
      prev_en = 1'b0;
      in_post = 1'b0;
      hi_n    = 0;
    end else begin
      if (lcd_en && !prev_en) begin
        chk("gap_short", {31'd0, in_post}, 0);
        chk("rw", {31'd0, lcd_rw}, 0);
        chk("setup_stable", {23'd0, cur}, {23'd0, prev_b});
        cap_q.push_back(cur);
        hold    = cur;
        hi_n    = 1;
        in_post = 1'b0;
      end else if (lcd_en) begin
        hi_n++;
        chk("en_stable", {23'd0, cur}, {23'd0, hold});
      end else if (prev_en) begin
        chk("en_width", hi_n, TEN);
        in_post  = 1'b1;
        post_n   = 1;
        post_len = (hold == 9'h001) ? TCLR : TCMD;
        chk("post_stable", {23'd0, cur}, {23'd0, hold});
      end else if (in_post) begin
        post_n++;
        chk("post_stable", {23'd0, cur}, {23'd0, hold});
      end
      if (in_post && post_n >= post_len) in_post = 1'b0;
      prev_en = lcd_en;
      prev_b  = cur;
    end
  end

  function automatic void model(input logic [15:0] v);
    int s, m;
    s = int'($signed(v));
    m = (s < 0) ? -s : s;
    exp_q.delete();
    exp_q.push_back(9'h080);
    exp_q.push_back({1'b1, (s < 0) ? 8'h2D : 8'h2B});
    for (int p = 10000; p >= 1; p /= 10)
      exp_q.push_back({1'b1, 8'(48 + (m / p) % 10)});
  endfunction

  task automatic init_seq();
    int hi = 0;
    int t  = 0;
    repeat (TPW) begin
      @(negedge clk);
      hi += int'(lcd_en);
    end
    chk("pwrup_quiet", hi, 0);
    while (!init_done && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("init_timeout", {31'd0, t < 3000}, 1);
    chk("init_count", cap_q.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < cap_q.size())
        chk("init_byte", {23'd0, cap_q[i]}, {23'd0, init_exp[i]});
    chk("init_ready", {31'd0, ready}, 1);
    chk("init_done", {31'd0, init_done}, 1);
  endtask

  task automatic send(input logic [15:0] v, input bit spam);
    int t = 0;
    int lat = 0;
    while (!ready && t < 1000) begin
      @(negedge clk);
      t++;
    end
    chk("pre_ready", {31'd0, ready}, 1);
    cap_q.delete();
    model(v);
    req    = 1'b1;
    numero = v;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    chk("ready_fall", {31'd0, ready}, 0);
    while (!ready && lat < 1000) begin
      if (spam && $urandom_range(0, 2) == 0) begin
        req    = 1'b1;
        numero = 16'($urandom);
      end else begin
        req = 1'b0;
      end
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    req = 1'b0;
    chk("latency", lat, LAT);
    chk("byte_count", cap_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < cap_q.size())
        chk($sformatf("char%0d_%04h", i, v),
            {23'd0, cap_q[i]}, {23'd0, exp_q[i]});
  endtask

  initial begin
    logic [15:0] dir[5] = '{16'h002A, 16'h8000, 16'hFFFF,
                            16'h7FFF, 16'h0000};
    int t;
    #1;
    chk("rst_en", {31'd0, lcd_en}, 0);
    chk("rst_data", {24'd0, lcd_data}, 0);
    chk("rst_rs", {31'd0, lcd_rs}, 0);
    chk("rst_ready", {31'd0, ready}, 0);
    chk("rst_init", {31'd0, init_done}, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    init_seq();

    foreach (dir[i]) send(dir[i], 1'b0);
    repeat (6) send(16'($urandom), 1'b0);
    send(16'h1234, 1'b1);
    send(16'($urandom), 1'b1);

    // reset while EN is high on a digit write
    @(negedge clk);
    req    = 1'b1;
    numero = 16'hBEEF;
    @(negedge clk);
    req = 1'b0;
    cap_q.delete();
    t = 0;
    while (!(cap_q.size() >= 3 && lcd_en) && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("mid_wait", {31'd0, t < 500}, 1);
    #1 rst = 1'b1;
    #1;
    chk("arst_en", {31'd0, lcd_en}, 0);
    chk("arst_data", {24'd0, lcd_data}, 0);
    chk("arst_rs", {31'd0, lcd_rs}, 0);
    chk("arst_rw", {31'd0, lcd_rw}, 0);
    chk("arst_ready", {31'd0, ready}, 0);
    chk("arst_init", {31'd0, init_done}, 0);
    repeat (3) @(negedge clk);
    cap_q.delete();
    rst = 1'b0;
    init_seq();
    send(16'hFFD6, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
